fmul_issue_wb: RTL and testbench



---
 rtl/fmul_pkg.sv | 29 ++
 rtl/fmul_issue_wb_if.sv | 30 +++
 rtl/fmul_res_fifo.sv | 53 +++++
 rtl/fmul_issue_wb.sv | 114 +++++++++++
 tb/tb_fmul_issue_wb.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmul_pkg.sv
// Shared types and defaults for the fmul issue/writeback shell.
//   FLT_W        operand/result width (IEEE single)
//   NSTAGE_DEF   default multiplier latency to y
//   OVF_LAT_DEF  default multiplier latency to ovf
//   TAG_W        destination tag width (sizes the shared records below)
//   DEPTH_DEF    default result FIFO depth
package fmul_pkg;

  localparam int unsigned FLT_W       = 32;
  localparam int unsigned NSTAGE_DEF  = 3;
  localparam int unsigned OVF_LAT_DEF = 2;
  localparam int unsigned TAG_W       = 6;
  localparam int unsigned DEPTH_DEF   = 4;

  // Result record as held in the FIFO and presented to writeback.
  typedef struct packed {
    logic [FLT_W-1:0] y;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } fmul_res_t;

  // Tracking entry that shadows one multiplier pipeline slot.
  typedef struct packed {
    logic             valid;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } fmul_trk_t;

endpackage

// File: rtl/fmul_issue_wb_if.sv
// Request/result handshake bundle for fmul_issue_wb.
//   req_*  : dispatch -> shell (valid/ready, two operands, destination tag)
//   res_*  : shell -> writeback (valid/ready, product, overflow, tag)
// master = dispatch/writeback side, slave = the shell.
interface fmul_issue_wb_if;
  import fmul_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [FLT_W-1:0] req_x1;
  logic [FLT_W-1:0] req_x2;
  logic [TAG_W-1:0] req_tag;

  logic             res_valid;
  logic             res_ready;
  logic [FLT_W-1:0] res_y;
  logic             res_ovf;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output req_valid, req_x1, req_x2, req_tag, res_ready,
    input  req_ready, res_valid, res_y, res_ovf, res_tag
  );

  modport slave (
    input  req_valid, req_x1, req_x2, req_tag, res_ready,
    output req_ready, res_valid, res_y, res_ovf, res_tag
  );

endinterface

// File: rtl/fmul_res_fifo.sv
// In-order result FIFO of fmul_res_t records.
//   clk, rstn        clock, async active-low reset
//   flush            synchronous clear of pointers and count (wins over push/pop)
//   push, push_data  write one record
//   pop              retire the head record
//   head             head record (valid when count != 0)
//   count            occupancy, 0..DEPTH
module fmul_res_fifo
  import fmul_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  fmul_res_t        push_data,
  input  logic             pop,
  output fmul_res_t        head,
  output logic [CNT_W-1:0] count
);

  fmul_res_t        mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fmul_issue_wb.sv
// Issue/writeback shell around a free-running, fixed-latency pipelined fmul.
//   clk, rstn     clock, async active-low reset
//   flush         synchronous discard of everything in flight and buffered
//   bus (slave)   req_* operand handshake in, res_* result handshake out
//   mul_x1/x2     operands to the multiplier (combinational copy of req_x1/x2)
//   mul_y/ovf     multiplier outputs, NSTAGE / OVF_LAT cycles after operands
//   busy          any operation in flight or buffered
// Build option: define FMUL_BYPASS_EN to let a tail result skip an empty FIFO.
module fmul_issue_wb
  import fmul_pkg::*;
#(
  parameter int unsigned NSTAGE  = NSTAGE_DEF,
  parameter int unsigned OVF_LAT = OVF_LAT_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  fmul_issue_wb_if.slave   bus,
  output logic [FLT_W-1:0] mul_x1,
  output logic [FLT_W-1:0] mul_x2,
  input  logic [FLT_W-1:0] mul_y,
  input  logic             mul_ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CW    = $clog2(DEPTH + NSTAGE + 1);

  fmul_trk_t        trk_q [NSTAGE];
  fmul_trk_t        trk_d [NSTAGE];
  fmul_trk_t        tail;
  fmul_res_t        tail_rec;
  fmul_res_t        head_rec;
  fmul_res_t        out_rec;
  logic [CW-1:0]    inflight;
  logic [CNT_W-1:0] occ;
  logic             accept;
  logic             res_valid;
  logic             fifo_push;
  logic             fifo_pop;

  assign mul_x1 = bus.req_x1;
  assign mul_x2 = bus.req_x2;

  // Credit covers both buffered and in-flight results, so a tail push can never
  // find the FIFO full. Same-cycle pops are deliberately not credited.
  assign bus.req_ready = ~flush & ((CW'(occ) + inflight) < CW'(DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;

  always_comb begin
    // ovf at slot 0 only matters when OVF_LAT is 0; otherwise it is overwritten.
    trk_d[0] = '{valid: accept, ovf: mul_ovf, tag: bus.req_tag};
    for (int unsigned i = 1; i < NSTAGE; i++) begin
      trk_d[i] = trk_q[i-1];
      if (i == OVF_LAT) trk_d[i].ovf = mul_ovf;
    end
    if (flush) begin
      for (int unsigned i = 0; i < NSTAGE; i++) trk_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NSTAGE; i++) trk_q[i] <= '0;
    end else begin
      trk_q <= trk_d;
    end
  end

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < NSTAGE; i++) inflight = inflight + CW'(trk_q[i].valid);
  end

  assign tail     = trk_q[NSTAGE-1];
  assign tail_rec = '{y: mul_y, ovf: tail.ovf, tag: tail.tag};

`ifdef FMUL_BYPASS_EN
  logic bypass;
  assign bypass    = (occ == '0) & tail.valid;
  assign res_valid = (occ != '0) | bypass;
  assign out_rec   = bypass ? tail_rec : head_rec;
  // A bypassed result taken this cycle never enters the FIFO.
  assign fifo_push = tail.valid & ~flush & ~(bypass & bus.res_ready);
  assign fifo_pop  = (occ != '0) & bus.res_ready;
`else
  assign res_valid = (occ != '0);
  assign out_rec   = head_rec;
  assign fifo_push = tail.valid & ~flush;
  assign fifo_pop  = res_valid & bus.res_ready;
`endif

  fmul_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (tail_rec),
    .pop       (fifo_pop),
    .head      (head_rec),
    .count     (occ)
  );

  assign bus.res_valid = res_valid;
  assign bus.res_y     = out_rec.y;
  assign bus.res_ovf   = out_rec.ovf;
  assign bus.res_tag   = out_rec.tag;

  assign busy = (inflight != '0) | (occ != '0);

endmodule

// File: tb/tb_fmul_issue_wb.sv
// Directed bench for fmul_issue_wb with a behavioural pipelined multiplier and
// an in-order scoreboard of expected results.
module tb_fmul_issue_wb;
  import fmul_pkg::*;

  localparam int unsigned NSTAGE  = 3;
  localparam int unsigned OVF_LAT = 2;
  localparam int unsigned DEPTH   = 4;
`ifdef FMUL_BYPASS_EN
  localparam int unsigned LAT = NSTAGE;
`else
  localparam int unsigned LAT = NSTAGE + 1;
`endif

  logic        clk;
  logic        rstn;
  logic        flush;
  logic [31:0] mul_x1;
  logic [31:0] mul_x2;
  logic [31:0] mul_y;
  logic        mul_ovf;
  logic        busy;

  int tests = 0;
  int fails = 0;

  fmul_issue_wb_if bus ();

  fmul_issue_wb #(
    .NSTAGE  (NSTAGE),
    .OVF_LAT (OVF_LAT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .bus     (bus),
    .mul_x1  (mul_x1),
    .mul_x2  (mul_x2),
    .mul_y   (mul_y),
    .mul_ovf (mul_ovf),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating single-precision multiply for normal operands: {ovf, y}.
  function automatic logic [32:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, e[7:0], m};
  endfunction

  // Multiplier model: y after NSTAGE edges, ovf after OVF_LAT edges.
  logic [32:0] ref_now;
  logic [31:0] yp [NSTAGE];
  logic        op [OVF_LAT];
  assign ref_now = fmul_ref(mul_x1, mul_x2);
  always @(posedge clk) begin
    yp[0] <= ref_now[31:0];
    op[0] <= ref_now[32];
    for (int i = 1; i < NSTAGE; i++) yp[i] <= yp[i-1];
    for (int i = 1; i < OVF_LAT; i++) op[i] <= op[i-1];
  end
  assign mul_y   = yp[NSTAGE-1];
  assign mul_ovf = op[OVF_LAT-1];

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Scoreboard entries {y, ovf, tag}; pushed on accept, popped on result handshake.
  logic [38:0] sb [$];

  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        chk("sb_unexpected_result", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          chk("sb_y", bus.res_y, sb[0][38:7]);
          chk("sb_ovf", 32'(bus.res_ovf), 32'(sb[0][6]));
          chk("sb_tag", 32'(bus.res_tag), 32'(sb[0][5:0]));
          void'(sb.pop_front());
        end
      end
      if (dut.fifo_push) chk("fifo_push_when_full", 32'(dut.occ < DEPTH), 32'd1);
      if (flush) sb.delete();
      if (bus.req_valid && bus.req_ready) sb.push_back({ref_now[31:0], ref_now[32], bus.req_tag});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
    bus.req_valid = 1'b1;
    bus.req_x1    = a;
    bus.req_x2    = b;
    bus.req_tag   = t;
  endtask

  // Single issue with res_ready=1; result must appear exactly LAT cycles later.
  task automatic issue_check(input logic [31:0] a, input logic [31:0] b, input logic [5:0] t,
                             input logic [31:0] ey, input logic eovf, input string nm);
    cyc();
    drive(a, b, t);
    bus.res_ready = 1'b1;
    mid();
    chk({nm, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    for (int k = 1; k <= int'(LAT); k++) begin
      cyc();
      bus.req_valid = 1'b0;
      mid();
      chk({nm, "_res_valid_lat"}, 32'(bus.res_valid), 32'(k == int'(LAT)));
    end
    chk({nm, "_res_y"}, bus.res_y, ey);
    chk({nm, "_res_ovf"}, 32'(bus.res_ovf), 32'(eovf));
    chk({nm, "_res_tag"}, 32'(bus.res_tag), 32'(t));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rstn          = 1'b0;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_x1    = '0;
    bus.req_x2    = '0;
    bus.req_tag   = '0;
    bus.res_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    mid();
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_y", bus.res_y, 32'd0);
    chk("rst_res_ovf", 32'(bus.res_ovf), 32'd0);
    chk("rst_res_tag", 32'(bus.res_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cyc();
    rstn = 1'b1;
    mid();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // 1.5 * 1.5, latency check
    issue_check(32'h3FC00000, 32'h3FC00000, 6'd5, 32'h40100000, 1'b0, "t1");
    idle(6);

    // Four back-to-back issues exhaust credit; drain afterwards
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(32'h3F800000, 32'h40000000, 6'(i));
      mid();
      chk("t2_req_ready_pre", 32'(bus.req_ready), 32'd1);
    end
    cyc();
    bus.req_valid = 1'b0;
    mid();
    chk("t2_req_ready_full", 32'(bus.req_ready), 32'd0);
    cyc();
    cyc();
    cyc();
    mid();
    chk("t2_occ_full", 32'(dut.occ), 32'd4);
    chk("t2_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t2_head_tag", 32'(bus.res_tag), 32'd0);
    cyc();
    bus.res_ready = 1'b1;
    mid();
    chk("t2_pop_no_credit", 32'(bus.req_ready), 32'd0);
    chk("t2_head_held", 32'(bus.res_tag), 32'd0);
    cyc();
    mid();
    chk("t2_req_ready_back", 32'(bus.req_ready), 32'd1);
    chk("t2_next_tag", 32'(bus.res_tag), 32'd1);
    idle(6);

    // Overflow passes through
    issue_check(32'h7F000000, 32'h7F000000, 6'd42, 32'h7F800000, 1'b1, "t3");
    idle(6);

    // Full credit: pop and tail push in the same cycle
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(32'h3F800000, 32'h40400000, 6'(10 + i));
    end
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    cyc();
    bus.res_ready = 1'b1;
    mid();
    chk("t4_occ_before", 32'(dut.occ), 32'd3);
    chk("t4_tail_push", 32'(dut.fifo_push), 32'd1);
    chk("t4_head_tag", 32'(bus.res_tag), 32'd10);
    cyc();
    mid();
    chk("t4_occ_after", 32'(dut.occ), 32'd3);
    chk("t4_next_tag", 32'(bus.res_tag), 32'd11);
    idle(6);

    // Flush with one buffered, one at the tail and one young op in flight
    bus.res_ready = 1'b0;
    cyc();
    drive(32'h3FC00000, 32'h3FC00000, 6'd20);
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    drive(32'h3FC00000, 32'h3FC00000, 6'd21);
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    drive(32'h3FC00000, 32'h3FC00000, 6'd22);
    cyc();
    flush         = 1'b1;
    bus.res_ready = 1'b1;
    drive(32'h3F800000, 32'h40000000, 6'd23);
    mid();
    chk("t5_flush_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t5_flush_busy", 32'(busy), 32'd1);
    chk("t5_flush_head_tag", 32'(bus.res_tag), 32'd20);
    cyc();
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    mid();
    chk("t5_post_busy", 32'(busy), 32'd0);
    chk("t5_post_res_valid", 32'(bus.res_valid), 32'd0);
    for (int k = 0; k < int'(NSTAGE) + 2; k++) begin
      cyc();
      mid();
      chk("t5_no_stale", 32'(bus.res_valid), 32'd0);
    end

    // Asynchronous reset mid-stream
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(32'h3F800000, 32'h40000000, 6'(30 + i));
    end
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    mid();
    chk("t6_pre_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_res_valid", 32'(bus.res_valid), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_res_y", bus.res_y, 32'd0);
    cyc();
    cyc();
    rstn = 1'b1;
    mid();
    chk("t6_req_ready", 32'(bus.req_ready), 32'd1);
    bus.res_ready = 1'b1;
    for (int k = 0; k < int'(NSTAGE) + 3; k++) begin
      cyc();
      mid();
      chk("t6_no_stale", 32'(bus.res_valid), 32'd0);
    end

    idle(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
